// File: rtl/demux3_pkg.sv
// Shared select encodings for the 1-to-3 stream distributor.
package demux3_pkg;

   typedef logic [1:0] sel_t;

   localparam sel_t SEL_A       = 2'd0;
   localparam sel_t SEL_B       = 2'd1;
   localparam sel_t SEL_C       = 2'd2;
   localparam sel_t SEL_ILLEGAL = 2'd3;

endpackage

// File: rtl/demux3_stream_if.sv
// Producer-side stream plus three consumer channels and status.
interface demux3_stream_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   import demux3_pkg::*;

   logic [WIDTH-1:0] in_data;
   sel_t             in_sel;
   logic             in_valid;
   logic             in_ready;

   logic [WIDTH-1:0] a_data;
   logic             a_valid;
   logic             a_ready;
   logic [WIDTH-1:0] b_data;
   logic             b_valid;
   logic             b_ready;
   logic [WIDTH-1:0] c_data;
   logic             c_valid;
   logic             c_ready;

   logic             err_illegal;
   logic [CNT_W-1:0] drop_cnt;

   modport slave (
      input  in_data, in_sel, in_valid,
      output in_ready,
      output a_data, a_valid,
      input  a_ready,
      output b_data, b_valid,
      input  b_ready,
      output c_data, c_valid,
      input  c_ready,
      output err_illegal, drop_cnt
   );

   modport master (
      output in_data, in_sel, in_valid,
      input  in_ready,
      input  a_data, a_valid,
      output a_ready,
      input  b_data, b_valid,
      output b_ready,
      input  c_data, c_valid,
      output c_ready,
      input  err_illegal, drop_cnt
   );

endinterface

// File: rtl/demux3_slot.sv
// One-entry register slice: load and drain may coincide for full rate.
module demux3_slot #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid
);

   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             w_drain;

   assign w_drain = r_valid & i_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
         end else if (w_drain) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;

endmodule

// File: rtl/demux3_stream.sv
// 1-to-3 stream distributor with per-channel registered slots.
// Optional DEMUX3_ROUNDROBIN_EN: target from an internal rotating pointer.
module demux3_stream
   import demux3_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic           clk,
   input  logic           rst,
   demux3_stream_if.slave s
);

   sel_t             w_sel;
   logic [2:0]       w_load;
   logic [2:0]       w_valid;
   logic [2:0]       w_ready;
   logic [2:0]       w_room;
   logic             w_in_ready;
   logic             w_xfer;
   logic [WIDTH-1:0] w_data_a;
   logic [WIDTH-1:0] w_data_b;
   logic [WIDTH-1:0] w_data_c;
   logic             w_err;
   logic [CNT_W-1:0] w_drop;

   assign w_ready = {s.c_ready, s.b_ready, s.a_ready};
   assign w_room  = ~w_valid | w_ready;

   always_comb begin
      w_in_ready = 1'b1;
      unique case (w_sel)
         SEL_A:   w_in_ready = w_room[0];
         SEL_B:   w_in_ready = w_room[1];
         SEL_C:   w_in_ready = w_room[2];
         default: w_in_ready = 1'b1;
      endcase
   end

   assign w_xfer    = s.in_valid & w_in_ready;
   assign w_load[0] = w_xfer & (w_sel == SEL_A);
   assign w_load[1] = w_xfer & (w_sel == SEL_B);
   assign w_load[2] = w_xfer & (w_sel == SEL_C);

`ifdef DEMUX3_ROUNDROBIN_EN
   sel_t r_ptr;
   logic w_sel_unused;

   assign w_sel_unused = ^s.in_sel;
   assign w_sel        = r_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= SEL_A;
      end else if (w_xfer) begin
         r_ptr <= (r_ptr == SEL_C) ? SEL_A : r_ptr + 2'd1;
      end
   end

   assign w_err  = 1'b0;
   assign w_drop = '0;
`else
   logic             r_err;
   logic [CNT_W-1:0] r_drop;
   logic             w_drop_hit;

   assign w_sel      = s.in_sel;
   assign w_drop_hit = w_xfer & (w_sel == SEL_ILLEGAL);

   // Counter saturates at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err  <= 1'b0;
         r_drop <= '0;
      end else if (w_drop_hit) begin
         r_err <= 1'b1;
         if (r_drop != '1) begin
            r_drop <= r_drop + CNT_W'(1);
         end
      end
   end

   assign w_err  = r_err;
   assign w_drop = r_drop;
`endif

   demux3_slot #(.WIDTH(WIDTH)) u_slot_a (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load[0]),
      .i_data  (s.in_data),
      .i_ready (w_ready[0]),
      .o_data  (w_data_a),
      .o_valid (w_valid[0])
   );

   demux3_slot #(.WIDTH(WIDTH)) u_slot_b (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load[1]),
      .i_data  (s.in_data),
      .i_ready (w_ready[1]),
      .o_data  (w_data_b),
      .o_valid (w_valid[1])
   );

   demux3_slot #(.WIDTH(WIDTH)) u_slot_c (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load[2]),
      .i_data  (s.in_data),
      .i_ready (w_ready[2]),
      .o_data  (w_data_c),
      .o_valid (w_valid[2])
   );

   assign s.in_ready    = w_in_ready;
   assign s.a_data      = w_data_a;
   assign s.a_valid     = w_valid[0];
   assign s.b_data      = w_data_b;
   assign s.b_valid     = w_valid[1];
   assign s.c_data      = w_data_c;
   assign s.c_valid     = w_valid[2];
   assign s.err_illegal = w_err;
   assign s.drop_cnt    = w_drop;

endmodule

// File: tb/tb_demux3_stream.sv
// Directed self-checking bench for demux3_stream (default and round-robin).
module tb_demux3_stream;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   demux3_stream_if #(.WIDTH(8), .CNT_W(8)) bus ();
   demux3_stream_if #(.WIDTH(8), .CNT_W(2)) bus2 ();

   demux3_stream #(.WIDTH(8), .CNT_W(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .s   (bus)
   );

   demux3_stream #(.WIDTH(8), .CNT_W(2)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .s   (bus2)
   );

   logic [7:0] td [3];
   logic [2:0] tv;

   always_comb begin
      td[0] = bus.a_data;
      td[1] = bus.b_data;
      td[2] = bus.c_data;
      tv    = {bus.c_valid, bus.b_valid, bus.a_valid};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are read on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_sel   = 2'd0;
      bus.in_data  = 8'h77;
      step();
      step();
      checks++;
      if (tv !== 3'b000) begin
         errors++;
         $display("FAIL reset_valid got %b want 000", tv);
      end
      checks++;
      if ({td[0], td[1], td[2]} !== 24'h0) begin
         errors++;
         $display("FAIL reset_data got %h %h %h want 0",
                  td[0], td[1], td[2]);
      end
      checks++;
      if (bus.err_illegal !== 1'b0 || bus.drop_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_err got %b %0d want 0 0",
                  bus.err_illegal, bus.drop_cnt);
      end
      rst = 1'b0;
      step();
      checks++;
      if (bus.a_valid !== 1'b1 || bus.a_data !== 8'h77) begin
         errors++;
         $display("FAIL reset_first got %b %h want 1 77",
                  bus.a_valid, bus.a_data);
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (tv !== 3'b000) begin
         errors++;
         $display("FAIL reset_mid got %b want 000", tv);
      end
   endtask

   task automatic test_steering();
      logic [7:0] vals [3];
      vals[0] = 8'h11;
      vals[1] = 8'h22;
      vals[2] = 8'h33;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_sel   = 2'(i);
         bus.in_data  = vals[i];
         #1;
         checks++;
         if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL steer_rdy%0d got %b want 1", i, bus.in_ready);
         end
         checks++;
         if (tv[i] !== 1'b0) begin
            errors++;
            $display("FAIL steer_early%0d got %b want 0", i, tv[i]);
         end
         step();
         checks++;
         if (tv[i] !== 1'b1 || td[i] !== vals[i]) begin
            errors++;
            $display("FAIL steer_ch%0d got %b %h want 1 %h",
                     i, tv[i], td[i], vals[i]);
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      bus.in_valid = 1'b1;
      bus.in_sel   = 2'd0;
      bus.in_data  = 8'h99;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_rdy got %b want 0", bus.in_ready);
      end
      step();
      checks++;
      if (bus.a_valid !== 1'b1 || bus.a_data !== 8'h11) begin
         errors++;
         $display("FAIL bp_hold got %b %h want 1 11",
                  bus.a_valid, bus.a_data);
      end
      bus.a_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.in_data = 8'hA0 + 8'(i);
         #1;
         checks++;
         if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_rdy%0d got %b want 1", i, bus.in_ready);
         end
         step();
         checks++;
         if (bus.a_valid !== 1'b1 || bus.a_data !== 8'hA0 + 8'(i)) begin
            errors++;
            $display("FAIL b2b_data%0d got %b %h want 1 %h",
                     i, bus.a_valid, bus.a_data, 8'hA0 + 8'(i));
         end
      end
      bus.in_valid = 1'b0;
      step();
      checks++;
      if (bus.a_valid !== 1'b0 || bus.a_data !== 8'hA4) begin
         errors++;
         $display("FAIL drain_hold got %b %h want 0 a4",
                  bus.a_valid, bus.a_data);
      end
      bus.a_ready = 1'b0;
   endtask

   task automatic test_independence();
      bus.c_ready = 1'b1;
      step();
      bus.c_ready = 1'b0;
      checks++;
      if (bus.c_valid !== 1'b0) begin
         errors++;
         $display("FAIL ind_cdrain got %b want 0", bus.c_valid);
      end
      bus.in_valid = 1'b1;
      bus.in_sel   = 2'd1;
      bus.in_data  = 8'hBB;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL ind_bblk got %b want 0", bus.in_ready);
      end
      bus.in_sel  = 2'd2;
      bus.in_data = 8'h5C;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ind_crdy got %b want 1", bus.in_ready);
      end
      step();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.c_valid !== 1'b1 || bus.c_data !== 8'h5C) begin
         errors++;
         $display("FAIL ind_c got %b %h want 1 5c",
                  bus.c_valid, bus.c_data);
      end
      checks++;
      if (bus.b_valid !== 1'b1 || bus.b_data !== 8'h22) begin
         errors++;
         $display("FAIL ind_b got %b %h want 1 22",
                  bus.b_valid, bus.b_data);
      end
   endtask

   task automatic test_illegal();
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_sel   = 2'd3;
         bus.in_data  = 8'hE0 + 8'(i);
         #1;
         checks++;
         if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ill_rdy%0d got %b want 1", i, bus.in_ready);
         end
         step();
      end
      bus.in_valid = 1'b0;
      step();
      checks++;
      if (tv !== 3'b110) begin
         errors++;
         $display("FAIL ill_valid got %b want 110", tv);
      end
      checks++;
      if (bus.err_illegal !== 1'b1 || bus.drop_cnt !== 8'd3) begin
         errors++;
         $display("FAIL ill_cnt got %b %0d want 1 3",
                  bus.err_illegal, bus.drop_cnt);
      end
      checks++;
      if ({td[1], td[2]} !== 16'h225C) begin
         errors++;
         $display("FAIL ill_data got %h %h want 22 5c", td[1], td[2]);
      end
   endtask

   task automatic test_saturate();
      int exp;
      for (int i = 0; i < 5; i++) begin
         bus2.in_valid = 1'b1;
         bus2.in_sel   = 2'd3;
         bus2.in_data  = 8'(i);
         step();
         exp = (i + 1 > 3) ? 3 : i + 1;
         checks++;
         if (bus2.drop_cnt !== 2'(exp) || bus2.err_illegal !== 1'b1) begin
            errors++;
            $display("FAIL sat%0d got %0d %b want %0d 1",
                     i, bus2.drop_cnt, bus2.err_illegal, exp);
         end
      end
      bus2.in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (bus2.drop_cnt !== 2'd0 || bus2.err_illegal !== 1'b0) begin
         errors++;
         $display("FAIL sat_rst got %0d %b want 0 0",
                  bus2.drop_cnt, bus2.err_illegal);
      end
   endtask

   task automatic test_roundrobin();
      int ch;
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.a_ready = 1'b1;
      bus.b_ready = 1'b1;
      bus.c_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.in_valid = 1'b1;
         bus.in_sel   = 2'd3;
         bus.in_data  = 8'(i + 1);
         step();
         ch = i % 3;
         checks++;
         if (tv[ch] !== 1'b1 || td[ch] !== 8'(i + 1)) begin
            errors++;
            $display("FAIL rr%0d ch%0d got %b %h want 1 %h",
                     i, ch, tv[ch], td[ch], 8'(i + 1));
         end
         checks++;
         if (bus.err_illegal !== 1'b0 || bus.drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rr_err%0d got %b %0d want 0 0",
                     i, bus.err_illegal, bus.drop_cnt);
         end
      end
      bus.in_data = 8'h41;
      step();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      step();
      rst = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h42;
      step();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.a_valid !== 1'b1 || bus.a_data !== 8'h42) begin
         errors++;
         $display("FAIL rr_rst got %b %h want 1 42",
                  bus.a_valid, bus.a_data);
      end
      checks++;
      if (bus.b_valid !== 1'b0) begin
         errors++;
         $display("FAIL rr_rst_b got %b want 0", bus.b_valid);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_sel    = 2'd0;
      bus.in_data   = 8'h00;
      bus.a_ready   = 1'b0;
      bus.b_ready   = 1'b0;
      bus.c_ready   = 1'b0;
      bus2.in_valid = 1'b0;
      bus2.in_sel   = 2'd0;
      bus2.in_data  = 8'h00;
      bus2.a_ready  = 1'b0;
      bus2.b_ready  = 1'b0;
      bus2.c_ready  = 1'b0;
      @(negedge clk);
      test_reset();
`ifdef DEMUX3_ROUNDROBIN_EN
      test_roundrobin();
`else
      test_steering();
      test_backpressure();
      test_independence();
      test_illegal();
      test_saturate();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/demux3_stream.md
Name: demux3_stream

Overview:
- 1-to-3 stream distributor; the write-side counterpart of the 3:1 select mux.
- Takes one valid/ready input stream and steers each word to channel A, B or C by a 2-bit select.
- Each output channel has a one-entry registered slot, so channels drain independently and a stalled channel blocks only words aimed at it.
- Used wherever a single producer feeds three consumers that the mux later recombines.

Parameters:
WIDTH, 8, data width of the input and of every output channel
CNT_W, 8, width of the dropped-word counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; synchronous, active-high
in_data  input  WIDTH  input word
in_sel  input  2  target channel: 0=A, 1=B, 2=C, 3=illegal
in_valid  input  1  input word present
in_ready  output  1  input word accepted this cycle when high with in_valid
a_data/b_data/c_data  output  WIDTH each  channel slot data
a_valid/b_valid/c_valid  output  1 each  channel slot full
a_ready/b_ready/c_ready  input  1 each  channel consumer accepts
err_illegal  output  1  sticky: a word with in_sel=3 was accepted
drop_cnt  output  CNT_W  count of discarded words, saturating

Behaviour:
- Reset: clk and rst only; synchronous, active-high. On rst=1 at a clock edge:
  - every x_valid=0 and every x_data=0;
  - err_illegal=0, drop_cnt=0, round-robin pointer=0.
  - Reset mid-operation silently discards buffered words.
- Handshakes:
  - Input transfer = in_valid & in_ready.
  - Output transfer on channel x = x_valid & x_ready.
- in_ready is combinational:
  - in_sel in 0..2: in_ready = ~x_valid[sel] | x_ready[sel] (slot empty, or being drained this same cycle).
  - in_sel=3: in_ready=1 (word is always consumed).
- Latency: a word accepted at edge N is visible on x_data with x_valid=1 after edge N. There is no combinational path from in_data to any output.
- Slot update per channel, evaluated at each edge:
  - load & drain: data replaced, valid stays 1. Sustained 1 word/cycle is supported.
  - load only: data captured, valid set.
  - drain only: valid cleared; data holds its last value.
  - neither: no change. x_data must stay stable while x_valid & ~x_ready.
- Channels not selected drain freely in the same cycle as a load to another channel.
- Illegal select: a word accepted with in_sel=3 is discarded.
  - err_illegal sets and stays set until rst.
  - drop_cnt increments by 1 and saturates at 2^CNT_W-1; it does not wrap.
- in_sel and in_data are only meaningful while in_valid=1. Values while in_valid=0 have no effect.
- The producer holds in_data and in_sel stable while in_valid & ~in_ready. The block does not check this.

Optional Feature:
- Macro: DEMUX3_ROUNDROBIN_EN.
- Defined:
  - in_sel is ignored; the target comes from an internal 2-bit pointer.
  - Pointer resets to 0 and advances 0→1→2→0 on each input transfer only.
  - in_ready = ~x_valid[ptr] | x_ready[ptr].
  - err_illegal and drop_cnt remain as ports, tied to 0.
- Undefined: select-driven behaviour as above; no pointer state exists.

Decomposition:
- Package demux3_pkg holds:
  - constants SEL_A=2'd0, SEL_B=2'd1, SEL_C=2'd2, SEL_ILLEGAL=2'd3;
  - typedef sel_t (2-bit).
- Sub-module demux3_slot: the one-entry register slice (load, drain, data, valid), parameterised by WIDTH and instantiated three times.
- The top level holds:
  - select decode;
  - the in_ready mux;
  - err/drop logic;
  - the optional pointer.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with in_valid=1, in_sel=0 → all x_valid=0, x_data=0, err_illegal=0, drop_cnt=0. First transfer occurs only after rst=0.
2. Steering: send 8'h11/sel0, 8'h22/sel1, 8'h33/sel2 with all x_ready=0 → a_data=11, b_data=22, c_data=33, each valid one cycle after its transfer; in_ready=1 for all three.
3. Backpressure and throughput:
   - With a_valid=1 and a_ready=0, offer sel0 → in_ready=0 and a_data holds.
   - Then drive a_ready=1 with back-to-back 8'hA0..8'hA4 on sel0 → one word per cycle and a_valid held high.
4. Independence: with B full and b_ready=0, send sel2 8'h5C → accepted, c_data=5C, b_data unchanged.
5. Illegal select:
   - Send 3 words with sel=3 → in_ready=1 each, no x_valid change, err_illegal=1, drop_cnt=3.
   - With CNT_W=2, send 5 such words → drop_cnt saturates at 3.
6. Round-robin (macro defined): 6 words 8'h01..8'h06 with in_sel=3 and all ready=1 → A gets 01,04; B gets 02,05; C gets 03,06. err_illegal stays 0. rst mid-stream resets the pointer to A.
